// File: rtl/motor_pkg.sv
// Shared command codes, mode/direction encodings and FSM states for motor_cmd_ramp.
// Pure declarations: no latency and no backpressure.
package motor_pkg;

  localparam logic [7:0] CMD_FWD   = 8'h1A;
  localparam logic [7:0] CMD_STOP  = 8'h2A;
  localparam logic [7:0] CMD_LEFT  = 8'h3A;
  localparam logic [7:0] CMD_RIGHT = 8'h4A;
  localparam logic [7:0] CMD_REV   = 8'h5A;

  typedef enum logic [2:0] {
    MODE_STOP  = 3'd0,
    MODE_FWD   = 3'd1,
    MODE_REV   = 3'd2,
    MODE_LEFT  = 3'd3,
    MODE_RIGHT = 3'd4
  } mode_e;

  typedef enum logic [1:0] {DIR_OFF, DIR_FWD, DIR_REV} dir_e;

  typedef enum logic [1:0] {S_STOP, S_RUN, S_DOWN, S_DEAD} state_e;

  function automatic logic cmd_known(input logic [7:0] code);
    return code inside {CMD_FWD, CMD_STOP, CMD_LEFT, CMD_RIGHT, CMD_REV};
  endfunction

  function automatic mode_e decode_cmd(input logic [7:0] code);
    case (code)
      CMD_FWD:   return MODE_FWD;
      CMD_LEFT:  return MODE_LEFT;
      CMD_RIGHT: return MODE_RIGHT;
      CMD_REV:   return MODE_REV;
      default:   return MODE_STOP;
    endcase
  endfunction

  // Turns spin the two sides in opposite directions.
  function automatic dir_e side_dir(input mode_e m, input logic right);
    case (m)
      MODE_FWD:   return DIR_FWD;
      MODE_REV:   return DIR_REV;
      MODE_LEFT:  return right ? DIR_FWD : DIR_REV;
      MODE_RIGHT: return right ? DIR_REV : DIR_FWD;
      default:    return DIR_OFF;
    endcase
  endfunction

endpackage

// File: rtl/duty_ramp.sv
// Slew-limited duty register: moves toward i_target by at most RAMP_STEP once every RAMP_DIV cycles.
// Latency: one tick per step; i_clear zeroes the duty on the next edge; no backpressure.
module duty_ramp #(
  parameter int             N         = 32,
  parameter logic [N-1:0]   RAMP_STEP = N'(32'h0100_0000),
  parameter int             RAMP_DIV  = 500
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] i_target,
  input  logic         i_clear,
  output logic [N-1:0] o_duty_cur
);

  localparam int            PW       = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(RAMP_DIV - 1);

  logic [PW-1:0] r_pre;
  logic [N-1:0]  r_cur;
  logic          w_tick;
  logic          w_up;
  logic [N-1:0]  w_diff;
  logic [N-1:0]  w_step;

  assign w_tick = (r_pre == PRE_LAST);

  // Prescaler free-runs regardless of FSM state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_pre <= '0;
    else        r_pre <= w_tick ? '0 : r_pre + PW'(1);
  end

  assign w_up   = (i_target > r_cur);
  assign w_diff = w_up ? (i_target - r_cur) : (r_cur - i_target);
  assign w_step = (w_diff > RAMP_STEP) ? RAMP_STEP : w_diff;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       r_cur <= '0;
    else if (i_clear) r_cur <= '0;
    else if (w_tick)  r_cur <= w_up ? (r_cur + w_step) : (r_cur - w_step);
  end

  assign o_duty_cur = r_cur;

endmodule

// File: rtl/motor_cmd_ramp.sv
// Command decode, direction-change FSM with ramp-down/dead time, and phase-accumulator PWM per channel.
// Command acts one cycle after cmd_valid; pins registered; no backpressure. MOTOR_WDOG_EN adds the silence watchdog.
module motor_cmd_ramp
  import motor_pkg::*;
#(
  parameter int           N         = 32,
  parameter int           NCH       = 4,
  parameter logic [N-1:0] PERIOD    = N'(85899),
  parameter logic [N-1:0] TURN_DUTY = N'(32'h0000_FFFF),
  parameter logic [N-1:0] RAMP_STEP = N'(32'h0100_0000),
  parameter int           RAMP_DIV  = 500,
  parameter int           DEAD_CYC  = 50000,
  parameter int           WDOG_CYC  = 25_000_000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [7:0]       signal,
  input  logic             cmd_valid,
  input  logic [N-1:0]     duty,
  output logic [2*NCH-1:0] pwm_out,
  output logic [2:0]       mode,
  output logic             busy,
  output logic             cmd_err,
  output logic             wdog_trip
);

  // One width serves both interval counters.
  localparam int CNT_W = $clog2(((DEAD_CYC > WDOG_CYC) ? DEAD_CYC : WDOG_CYC) + 1);

  mode_e            r_pending;
  mode_e            r_mode;
  mode_e            w_mode_nxt;
  state_e           r_state;
  state_e           w_state_nxt;
  logic             r_cmd_err;
  logic [N-1:0]     r_acc;
  logic [2*NCH-1:0] r_pwm_out;
  logic [2*NCH-1:0] w_pins;
  logic [CNT_W-1:0] r_dead_cnt;
  logic             w_dead_done;
  logic [N-1:0]     w_run_target;
  logic [N-1:0]     w_target;
  logic             w_clear;
  logic [N-1:0]     w_duty_cur;
  logic             w_pwm;
  logic             w_wdog_exp;

`ifdef MOTOR_WDOG_EN
  logic [CNT_W-1:0] r_wdog_cnt;
  logic             r_wdog_done;
  logic             r_wdog_trip;

  assign w_wdog_exp = !cmd_valid && !r_wdog_done && (r_wdog_cnt == CNT_W'(WDOG_CYC - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wdog_cnt  <= '0;
      r_wdog_done <= 1'b0;
      r_wdog_trip <= 1'b0;
    end else begin
      r_wdog_trip <= w_wdog_exp;
      if (cmd_valid) begin
        r_wdog_cnt  <= '0;
        r_wdog_done <= 1'b0;
      end else if (w_wdog_exp) begin
        r_wdog_cnt  <= '0;
        r_wdog_done <= 1'b1;
      end else if (!r_wdog_done) begin
        r_wdog_cnt  <= r_wdog_cnt + CNT_W'(1);
      end
    end
  end

  assign wdog_trip = r_wdog_trip;
`else
  assign w_wdog_exp = 1'b0;
  assign wdog_trip  = 1'b0;
`endif

  // Last command wins; a simultaneous command beats watchdog expiry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pending <= MODE_STOP;
      r_cmd_err <= 1'b0;
    end else begin
      r_cmd_err <= cmd_valid && !cmd_known(signal);
      if (cmd_valid)       r_pending <= decode_cmd(signal);
      else if (w_wdog_exp) r_pending <= MODE_STOP;
    end
  end

  always_comb begin
    w_run_target = '0;
    case (r_mode)
      MODE_FWD, MODE_REV:    w_run_target = duty;
      MODE_LEFT, MODE_RIGHT: w_run_target = TURN_DUTY;
      default:               w_run_target = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_STOP;
      r_mode  <= MODE_STOP;
    end else begin
      r_state <= w_state_nxt;
      r_mode  <= w_mode_nxt;
    end
  end

  assign w_dead_done = (r_dead_cnt == CNT_W'(DEAD_CYC - 1));

  always_comb begin
    w_state_nxt = r_state;
    w_mode_nxt  = r_mode;
    w_target    = '0;
    w_clear     = 1'b0;
    case (r_state)
      S_STOP: begin
        w_clear = 1'b1;
        if (r_pending != MODE_STOP) begin
          w_mode_nxt  = r_pending;
          w_state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        w_target = w_run_target;
        if (r_pending != r_mode) w_state_nxt = S_DOWN;
      end
      S_DOWN: begin
        if (r_pending == r_mode)   w_state_nxt = S_RUN;
        else if (w_duty_cur == '0) w_state_nxt = S_DEAD;
      end
      S_DEAD: begin
        w_clear = 1'b1;
        if (w_dead_done) begin
          w_mode_nxt  = r_pending;
          w_state_nxt = (r_pending == MODE_STOP) ? S_STOP : S_RUN;
        end
      end
      default: w_state_nxt = S_STOP;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                r_dead_cnt <= '0;
    else if (r_state != S_DEAD) r_dead_cnt <= '0;
    else                       r_dead_cnt <= r_dead_cnt + CNT_W'(1);
  end

  duty_ramp #(
    .N         (N),
    .RAMP_STEP (RAMP_STEP),
    .RAMP_DIV  (RAMP_DIV)
  ) u_ramp (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_target   (w_target),
    .i_clear    (w_clear),
    .o_duty_cur (w_duty_cur)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_acc <= '0;
    else        r_acc <= r_acc + PERIOD;
  end

  assign w_pwm = (r_acc < w_duty_cur);

  // Only one pin per channel is ever driven, so in1/in2 can never overlap.
  always_comb begin
    w_pins = '0;
    if (r_state != S_DEAD) begin
      for (int c = 0; c < NCH; c++) begin
        w_pins[2*c]   = w_pwm && (side_dir(r_mode, c >= NCH/2) == DIR_FWD);
        w_pins[2*c+1] = w_pwm && (side_dir(r_mode, c >= NCH/2) == DIR_REV);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_pwm_out <= '0;
    else        r_pwm_out <= w_pins;
  end

  assign pwm_out = r_pwm_out;
  assign mode    = r_mode;
  assign busy    = (r_state == S_DOWN) || (r_state == S_DEAD);
  assign cmd_err = r_cmd_err;

endmodule

// File: tb/tb_motor_cmd_ramp.sv
// Directed + randomized bench for motor_cmd_ramp against a per-cycle behavioural model of the motor rules.
module tb_motor_cmd_ramp;

  localparam int N = 16, NCH = 4, PERIOD = 4096, STEP = 4096, RAMP_DIV = 1;
  localparam int DEAD_CYC = 4, WDOG_CYC = 100, TURN = 65535;
  localparam int P_STOP = 0, P_RUN = 1, P_DOWN = 2, P_DEAD = 3;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [7:0]       signal = 8'h00;
  logic             cmd_valid = 1'b0;
  logic [N-1:0]     duty = '0;
  logic [2*NCH-1:0] pwm_out;
  logic [2:0]       mode;
  logic             busy, cmd_err, wdog_trip;

  motor_cmd_ramp #(
    .N(N), .NCH(NCH), .PERIOD(16'd4096), .TURN_DUTY(16'hFFFF), .RAMP_STEP(16'h1000),
    .RAMP_DIV(RAMP_DIV), .DEAD_CYC(DEAD_CYC), .WDOG_CYC(WDOG_CYC)
  ) dut (
    .clk(clk), .rst_n(rst_n), .signal(signal), .cmd_valid(cmd_valid), .duty(duty),
    .pwm_out(pwm_out), .mode(mode), .busy(busy), .cmd_err(cmd_err), .wdog_trip(wdog_trip)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;

  // Model state, as visible just after a clock edge.
  int m_pend, m_mode, m_ph, m_cur, m_acc, m_pre, m_dead, m_idle, m_pins, m_err, m_trip;
  bit m_quiet;
  int cnt1[NCH], cnt2[NCH];
  int trips;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int decode(input int code);
    case (code)
      'h1A: return 1;
      'h5A: return 2;
      'h3A: return 3;
      'h4A: return 4;
      default: return 0;
    endcase
  endfunction

  function automatic bit known(input int code);
    return code == 'h1A || code == 'h2A || code == 'h3A || code == 'h4A || code == 'h5A;
  endfunction

  // +1 forward, -1 reverse, 0 off for one side of the car.
  function automatic int side(input int md, input bit right);
    case (md)
      1: return 1;
      2: return -1;
      3: return right ? 1 : -1;
      4: return right ? -1 : 1;
      default: return 0;
    endcase
  endfunction

  task automatic model_reset();
    m_pend = 0; m_mode = 0; m_ph = P_STOP; m_cur = 0; m_acc = 0; m_pre = 0;
    m_dead = 0; m_idle = 0; m_pins = 0; m_err = 0; m_trip = 0; m_quiet = 0;
  endtask

  task automatic model_edge();
    int n_pins, n_cur, n_ph, n_mode, n_dead, n_pend, n_trip, tgt, s;
    bit p, tick;
    n_pins = 0;
    p = m_acc < m_cur;
    if (m_ph != P_DEAD)
      for (int c = 0; c < NCH; c++) begin
        s = side(m_mode, c >= NCH/2);
        if (p && s == 1)  n_pins |= 1 << (2*c);
        if (p && s == -1) n_pins |= 1 << (2*c + 1);
      end
    tick = (m_pre == RAMP_DIV - 1);
    tgt = 0;
    if (m_ph == P_RUN) tgt = (m_mode == 1 || m_mode == 2) ? int'(duty) : (m_mode >= 3 ? TURN : 0);
    n_cur = m_cur;
    if (m_ph == P_STOP || m_ph == P_DEAD) n_cur = 0;
    else if (tick) begin
      if (tgt > m_cur) n_cur = m_cur + ((tgt - m_cur) < STEP ? (tgt - m_cur) : STEP);
      else             n_cur = m_cur - ((m_cur - tgt) < STEP ? (m_cur - tgt) : STEP);
    end
    n_ph = m_ph; n_mode = m_mode; n_dead = 0;
    case (m_ph)
      P_STOP: if (m_pend != 0) begin n_mode = m_pend; n_ph = P_RUN; end
      P_RUN:  if (m_pend != m_mode) n_ph = P_DOWN;
      P_DOWN: if (m_pend == m_mode) n_ph = P_RUN; else if (m_cur == 0) n_ph = P_DEAD;
      default: begin
        n_dead = m_dead + 1;
        if (n_dead == DEAD_CYC) begin n_mode = m_pend; n_ph = (m_pend == 0) ? P_STOP : P_RUN; end
      end
    endcase
    n_pend = m_pend; n_trip = 0;
    if (cmd_valid) begin
      n_pend = decode(signal); m_idle = 0; m_quiet = 0;
    end
`ifdef MOTOR_WDOG_EN
    else if (!m_quiet) begin
      m_idle++;
      if (m_idle == WDOG_CYC) begin n_trip = 1; m_quiet = 1; n_pend = 0; m_idle = 0; end
    end
`endif
    m_err  = (cmd_valid && !known(signal)) ? 1 : 0;
    m_trip = n_trip; m_pend = n_pend; m_pins = n_pins; m_cur = n_cur;
    m_ph = n_ph; m_mode = n_mode; m_dead = n_dead;
    m_acc = (m_acc + PERIOD) % 65536;
    m_pre = tick ? 0 : m_pre + 1;
  endtask

  task automatic compare();
    check("pwm_out", 32'(pwm_out), 32'(m_pins));
    check("mode", 32'(mode), 32'(m_mode));
    check("busy", 32'(busy), 32'(m_ph == P_DOWN || m_ph == P_DEAD));
    check("cmd_err", 32'(cmd_err), 32'(m_err));
    check("wdog_trip", 32'(wdog_trip), 32'(m_trip));
    check("in1_in2_overlap", 32'(pwm_out & (pwm_out >> 1) & 8'h55), 32'd0);
  endtask

  // Called at a falling edge; drives inputs, clocks once, checks at the next falling edge.
  task automatic step(input logic [7:0] s, input bit v);
    signal = s; cmd_valid = v;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare();
    if (wdog_trip) trips++;
  endtask

  task automatic win(input int len);
    for (int c = 0; c < NCH; c++) begin cnt1[c] = 0; cnt2[c] = 0; end
    for (int k = 0; k < len; k++) begin
      step(8'h00, 0);
      for (int c = 0; c < NCH; c++) begin
        cnt1[c] += int'(pwm_out[2*c]);
        cnt2[c] += int'(pwm_out[2*c+1]);
      end
    end
  endtask

  initial begin
    logic [7:0] codes [5];
    int gap, idx;
    bit seen;
    codes = '{8'h1A, 8'h2A, 8'h3A, 8'h4A, 8'h5A};
    trips = 0;
    model_reset();
    repeat (3) @(negedge clk);
    check("reset_pwm_out", 32'(pwm_out), 32'd0);
    check("reset_mode", 32'(mode), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_cmd_err", 32'(cmd_err), 32'd0);
    check("reset_wdog_trip", 32'(wdog_trip), 32'd0);
    rst_n = 1'b1;

    // Forward at half duty: in1 high 8 of every 16 cycles, in2 quiet.
    duty = 16'h8000;
    step(8'h1A, 1);
    repeat (30) step(8'h00, 0);
    win(16);
    for (int c = 0; c < NCH; c++) begin
      check($sformatf("fwd_in1_ch%0d", c), 32'(cnt1[c]), 32'd8);
      check($sformatf("fwd_in2_ch%0d", c), 32'(cnt2[c]), 32'd0);
    end

    // Reverse through ramp-down and dead time.
    step(8'h5A, 1);
    step(8'h00, 0);
    check("rev_busy_rises", 32'(busy), 32'd1);
    repeat (40) step(8'h00, 0);
    check("rev_mode", 32'(mode), 32'd2);
    win(16);
    for (int c = 0; c < NCH; c++) check($sformatf("rev_in2_ch%0d", c), 32'(cnt2[c]), 32'd8);

    // Stop, then left turn capped at full duty.
    step(8'h2A, 1);
    repeat (30) step(8'h00, 0);
    check("stop_mode", 32'(mode), 32'd0);
    step(8'h3A, 1);
    repeat (40) step(8'h00, 0);
    win(16);
    for (int c = 0; c < NCH; c++) begin
      check($sformatf("left_active_ch%0d", c), 32'(c < NCH/2 ? cnt2[c] : cnt1[c]), 32'd16);
      check($sformatf("left_idle_ch%0d", c), 32'(c < NCH/2 ? cnt1[c] : cnt2[c]), 32'd0);
    end

    // Forward, STOP, then FWD again while ramping down: straight back to run.
    step(8'h1A, 1);
    repeat (40) step(8'h00, 0);
    step(8'h2A, 1);
    step(8'h00, 0);
    step(8'h00, 0);
    step(8'h1A, 1);
    for (int k = 0; k < 12; k++) begin
      step(8'h00, 0);
      check("reclaim_mode_fwd", 32'(mode), 32'd1);
    end
    check("reclaim_not_busy", 32'(busy), 32'd0);

    // Unknown code: single-cycle error pulse, then ramp down to STOP.
    step(8'h77, 1);
    check("err_pulse", 32'(cmd_err), 32'd1);
    step(8'h00, 0);
    check("err_pulse_len", 32'(cmd_err), 32'd0);
    repeat (25) step(8'h00, 0);
    check("err_stop_mode", 32'(mode), 32'd0);

    // Command silence.
    trips = 0;
    step(8'h1A, 1);
    repeat (130) step(8'h00, 0);
`ifdef MOTOR_WDOG_EN
    check("wdog_trips", 32'(trips), 32'd1);
    check("wdog_mode", 32'(mode), 32'd0);
`else
    check("wdog_trips", 32'(trips), 32'd0);
    check("wdog_mode", 32'(mode), 32'd1);
`endif

    // Asynchronous reset while pins are toggling.
    step(8'h1A, 1);
    seen = 0;
    for (int k = 0; k < 32 && !seen; k++) begin
      step(8'h00, 0);
      seen = (pwm_out != 0);
    end
    check("pwm_active_before_reset", 32'(seen), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_pwm", 32'(pwm_out), 32'd0);
    check("async_rst_mode", 32'(mode), 32'd0);
    check("async_rst_busy", 32'(busy), 32'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;

    // Random commands, gaps and live duty changes.
    for (int b = 0; b < 40; b++) begin
      idx = $urandom_range(0, 5);
      if ($urandom_range(0, 1) == 1) duty = 16'($urandom_range(0, 65535));
      step(idx == 5 ? 8'($urandom_range(0, 255)) : codes[idx], 1);
      gap = $urandom_range(0, 130);
      for (int k = 0; k < gap; k++) begin
        if ($urandom_range(0, 19) == 0) duty = 16'($urandom_range(0, 65535));
        step(8'h00, 0);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
